// File: rtl/iommu_reg_to_axi_lite.sv
// RegIF initiator -> AXI4-Lite manager bridge.
// One transaction in flight; a response timeout answers the initiator with an
// error and then drains whatever the AXI side still owes before going idle.

package iommu_reg_to_axi_lite_pkg;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    prot;
  } axi_ax_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } axi_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } axi_lite_rsp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          valid;
  } reg_req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          ready;
  } reg_rsp_t;
endpackage

module iommu_reg_to_axi_lite #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter type axi_lite_req_t = iommu_reg_to_axi_lite_pkg::axi_lite_req_t,
  parameter type axi_lite_rsp_t = iommu_reg_to_axi_lite_pkg::axi_lite_rsp_t,
  parameter type reg_req_t      = iommu_reg_to_axi_lite_pkg::reg_req_t,
  parameter type reg_rsp_t      = iommu_reg_to_axi_lite_pkg::reg_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  reg_req_t      reg_req_i,
  output reg_rsp_t      reg_rsp_o,
  output axi_lite_req_t axi_lite_req_o,
  input  axi_lite_rsp_t axi_lite_rsp_i,
  output logic          busy_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DRAIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_wr;
  logic             rsp_pend;  // AXI response still owed after a timeout
  logic             drain_q;   // leave RESP through DRAIN

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_left, w_left, ar_left;
  logic tmo, rsp_done;

  assign aw_hs   = axi_lite_req_o.aw_valid & axi_lite_rsp_i.aw_ready;
  assign w_hs    = axi_lite_req_o.w_valid  & axi_lite_rsp_i.w_ready;
  assign ar_hs   = axi_lite_req_o.ar_valid & axi_lite_rsp_i.ar_ready;
  assign b_hs    = axi_lite_req_o.b_ready  & axi_lite_rsp_i.b_valid;
  assign r_hs    = axi_lite_req_o.r_ready  & axi_lite_rsp_i.r_valid;
  // request channels still not accepted after this edge
  assign aw_left = axi_lite_req_o.aw_valid & ~axi_lite_rsp_i.aw_ready;
  assign w_left  = axi_lite_req_o.w_valid  & ~axi_lite_rsp_i.w_ready;
  assign ar_left = axi_lite_req_o.ar_valid & ~axi_lite_rsp_i.ar_ready;

  assign tmo      = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  // a response landing on the expiry cycle wins over the timeout
  assign rsp_done = ((state == WR_RESP) && b_hs) || ((state == RD_RESP) && r_hs);

  // Transaction FSM; every output is a register written here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cnt            <= '0;
      is_wr          <= 1'b0;
      rsp_pend       <= 1'b0;
      drain_q        <= 1'b0;
      axi_lite_req_o <= '0;
      reg_rsp_o      <= '0;
      busy_o         <= 1'b0;
    end else begin
      // each request channel drops only on its own handshake, in any state
      if (aw_hs) axi_lite_req_o.aw_valid <= 1'b0;
      if (w_hs)  axi_lite_req_o.w_valid  <= 1'b0;
      if (ar_hs) axi_lite_req_o.ar_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (reg_req_i.valid) begin
            cnt                   <= '0;
            is_wr                 <= reg_req_i.write;
            busy_o                <= 1'b1;
            axi_lite_req_o.aw.addr <= ADDR_WIDTH'(reg_req_i.addr);
            axi_lite_req_o.ar.addr <= ADDR_WIDTH'(reg_req_i.addr);
            axi_lite_req_o.w.data  <= DATA_WIDTH'(reg_req_i.wdata);
            axi_lite_req_o.w.strb  <= STRB_WIDTH'(reg_req_i.wstrb);
            if (reg_req_i.write) begin
              axi_lite_req_o.aw_valid <= 1'b1;
              axi_lite_req_o.w_valid  <= 1'b1;
              state                   <= WR_REQ;
            end else begin
              axi_lite_req_o.ar_valid <= 1'b1;
              state                   <= RD_REQ;
            end
          end
        end

        WR_REQ, WR_RESP, RD_REQ, RD_RESP: begin
          if (rsp_done) begin
            reg_rsp_o.ready        <= 1'b1;
            reg_rsp_o.error        <= is_wr ? (axi_lite_rsp_i.b.resp != RESP_OKAY)
                                            : (axi_lite_rsp_i.r.resp != RESP_OKAY);
            reg_rsp_o.rdata        <= is_wr ? '0 : axi_lite_rsp_i.r.data;
            axi_lite_req_o.b_ready <= 1'b0;
            axi_lite_req_o.r_ready <= 1'b0;
            drain_q                <= 1'b0;
            state                  <= RESP;
          end else if (tmo) begin
            // answer now, remember the AXI side still owes us a response
            reg_rsp_o.ready <= 1'b1;
            reg_rsp_o.error <= 1'b1;
            reg_rsp_o.rdata <= '0;
            rsp_pend        <= 1'b1;
            drain_q         <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if ((state == WR_REQ) && !aw_left && !w_left) begin
              axi_lite_req_o.b_ready <= 1'b1;
              state                  <= WR_RESP;
            end
            if ((state == RD_REQ) && ar_hs) begin
              axi_lite_req_o.r_ready <= 1'b1;
              state                  <= RD_RESP;
            end
          end
        end

        RESP: begin
          reg_rsp_o.ready <= 1'b0;
          if (b_hs) begin axi_lite_req_o.b_ready <= 1'b0; rsp_pend <= 1'b0; end
          if (r_hs) begin axi_lite_req_o.r_ready <= 1'b0; rsp_pend <= 1'b0; end
          if (drain_q) begin
            state <= DRAIN;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        DRAIN: begin
          if (b_hs) begin axi_lite_req_o.b_ready <= 1'b0; rsp_pend <= 1'b0; end
          if (r_hs) begin axi_lite_req_o.r_ready <= 1'b0; rsp_pend <= 1'b0; end
          // open the response channel once its request side has gone through
          if (rsp_pend && is_wr && !aw_left && !w_left && !axi_lite_req_o.b_ready)
            axi_lite_req_o.b_ready <= 1'b1;
          if (rsp_pend && !is_wr && !ar_left && !axi_lite_req_o.r_ready)
            axi_lite_req_o.r_ready <= 1'b1;
          if (!aw_left && !w_left && !ar_left && (!rsp_pend || b_hs || r_hs)) begin
            drain_q <= 1'b0;
            state   <= IDLE;
            busy_o  <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
